// File: rtl/udp_tx_arbiter.sv
// Packet-level round-robin merge of NUM_INPUTS UDP byte streams onto one transmit port.
// The grant is held from the first byte to the last byte, and each packet's byte count is checked against its declared length.
module udp_tx_arbiter #(
    parameter int NUM_INPUTS   = 4,
    parameter int LENGTH_WIDTH = 16,
    parameter int INDEX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic [NUM_INPUTS-1:0]              S_udp_valid,
    input  logic [NUM_INPUTS*8-1:0]            S_udp_data,
    input  logic [NUM_INPUTS-1:0]              S_udp_last,
    input  logic [NUM_INPUTS*LENGTH_WIDTH-1:0] S_udp_length,
    output logic [NUM_INPUTS-1:0]              S_udp_ready,
    output logic                               M_udp_valid,
    output logic [7:0]                         M_udp_data,
    output logic                               M_udp_last,
    output logic [LENGTH_WIDTH-1:0]            M_udp_length,
    input  logic                               M_udp_ready,
    output logic [INDEX_WIDTH-1:0]             Grant_index,
    output logic                               Grant_active,
    output logic                               Length_error,
    output logic                               Fsm_state
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [INDEX_WIDTH-1:0]  rr_pointer;
    logic [INDEX_WIDTH-1:0]  winner;
    logic                    winner_found;
    logic [INDEX_WIDTH:0]    cand;
    logic [LENGTH_WIDTH:0]   byte_count;
    logic [LENGTH_WIDTH:0]   count_plus_one;
    logic                    overrun_seen;
    logic                    transfer;
    logic                    last_transfer;
    logic [7:0]              data_arr   [NUM_INPUTS];
    logic [LENGTH_WIDTH-1:0] length_arr [NUM_INPUTS];

    assign Grant_active = (state == S_ACTIVE);
    assign Fsm_state    = state;

    // A beat moves only on a cycle where M_udp_valid && M_udp_ready; the
    // granted source sees M_udp_ready directly and every other source sees 0.
    assign transfer       = M_udp_valid && M_udp_ready;
    assign last_transfer  = transfer && M_udp_last;
    assign count_plus_one = (byte_count == '1) ? byte_count : byte_count + 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            data_arr[i]   = S_udp_data[i*8 +: 8];
            length_arr[i] = S_udp_length[i*LENGTH_WIDTH +: LENGTH_WIDTH];
        end
    end

    // First valid input at or after rr_pointer, wrapping modulo NUM_INPUTS.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            cand = {1'b0, rr_pointer} + (INDEX_WIDTH+1)'(i);
            if (cand >= (INDEX_WIDTH+1)'(NUM_INPUTS)) begin
                cand = cand - (INDEX_WIDTH+1)'(NUM_INPUTS);
            end
            if (!winner_found && S_udp_valid[cand[INDEX_WIDTH-1:0]]) begin
                winner_found = 1'b1;
                winner       = cand[INDEX_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        M_udp_valid  = 1'b0;
        M_udp_data   = '0;
        M_udp_last   = 1'b0;
        M_udp_length = '0;
        S_udp_ready  = '0;
        case (state)
            S_IDLE: begin
                if (winner_found) begin
                    state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                M_udp_valid              = S_udp_valid[Grant_index];
                M_udp_data               = data_arr[Grant_index];
                M_udp_last               = S_udp_last[Grant_index];
                M_udp_length             = length_arr[Grant_index];
                S_udp_ready[Grant_index] = M_udp_ready;
                if (last_transfer) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rr_pointer   <= '0;
            Grant_index  <= '0;
            byte_count   <= '0;
            overrun_seen <= 1'b0;
            Length_error <= 1'b0;
        end else begin
            Length_error <= 1'b0;
            if (state == S_IDLE) begin
                if (winner_found) begin
                    Grant_index  <= winner;
                    byte_count   <= '0;
                    overrun_seen <= 1'b0;
                end
            end else if (transfer) begin
                byte_count <= count_plus_one;
                if (M_udp_last) begin
                    rr_pointer <= (Grant_index == INDEX_WIDTH'(NUM_INPUTS - 1)) ?
                                  '0 : Grant_index + 1'b1;
                    if (count_plus_one != {1'b0, M_udp_length} && !overrun_seen) begin
                        Length_error <= 1'b1;
                    end
                end else if (count_plus_one == {1'b0, M_udp_length} && !overrun_seen) begin
                    // Declared length used up with no last: flag once, keep forwarding.
                    Length_error <= 1'b1;
                    overrun_seen <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: per-input packet sources, a round-robin packet-order model
// feeding an expected-beat queue, and a monitor that checks every output beat and error pulse.
module tb_udp_tx_arbiter;

    localparam int NI = 4;
    localparam int LW = 16;

    logic             clk;
    logic             rst_n;
    logic [NI-1:0]    S_udp_valid;
    logic [NI*8-1:0]  S_udp_data;
    logic [NI-1:0]    S_udp_last;
    logic [NI*LW-1:0] S_udp_length;
    logic [NI-1:0]    S_udp_ready;
    logic             M_udp_valid;
    logic [7:0]       M_udp_data;
    logic             M_udp_last;
    logic [LW-1:0]    M_udp_length;
    logic             M_udp_ready;
    logic [1:0]       Grant_index;
    logic             Grant_active;
    logic             Length_error;
    logic             Fsm_state;

    udp_tx_arbiter #(.NUM_INPUTS(NI), .LENGTH_WIDTH(LW), .INDEX_WIDTH(2)) dut (
        .Clk(clk), .Rst_n(rst_n),
        .S_udp_valid(S_udp_valid), .S_udp_data(S_udp_data), .S_udp_last(S_udp_last),
        .S_udp_length(S_udp_length), .S_udp_ready(S_udp_ready),
        .M_udp_valid(M_udp_valid), .M_udp_data(M_udp_data), .M_udp_last(M_udp_last),
        .M_udp_length(M_udp_length), .M_udp_ready(M_udp_ready),
        .Grant_index(Grant_index), .Grant_active(Grant_active),
        .Length_error(Length_error), .Fsm_state(Fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    // source beat: {length[15:0], last, data[7:0]}
    logic [24:0] src_q [NI][$];
    // model beat:  {err_after, length[15:0], last, data[7:0]}
    logic [25:0] mdl_q [NI][$];
    // expected output beat: {grant[1:0], err_after, length, last, data}
    logic [27:0] exp_q [$];
    logic [NI-1:0] src_mid;
    int mdl_ptr;
    int ready_pct;
    int gap_pct;
    bit strict;
    int beat_count;
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_packet(input int idx, input int decl_len, input int nbytes, input bit seq_data);
        int err_pos;
        logic [7:0] d;
        logic last;
        logic err;
        if (nbytes == decl_len) err_pos = 0;
        else if (nbytes > decl_len && decl_len >= 1) err_pos = decl_len;
        else err_pos = nbytes;
        for (int k = 0; k < nbytes; k++) begin
            d    = seq_data ? 8'(k + 1) : 8'($urandom_range(0, 255));
            last = (k == nbytes - 1);
            err  = (k + 1 == err_pos);
            src_q[idx].push_back({LW'(decl_len), last, d});
            mdl_q[idx].push_back({err, LW'(decl_len), last, d});
        end
    endtask

    // Packet order: scan inputs from the pointer, whole packet of the first
    // input with pending data goes out, pointer moves past it.
    task automatic build_expected();
        int g;
        bit found;
        logic [25:0] e;
        forever begin
            found = 0;
            g = 0;
            for (int k = 0; k < NI; k++) begin
                if (!found && mdl_q[(mdl_ptr + k) % NI].size() > 0) begin
                    found = 1;
                    g = (mdl_ptr + k) % NI;
                end
            end
            if (!found) break;
            do begin
                e = mdl_q[g].pop_front();
                exp_q.push_back({2'(g), e});
            end while (!e[8]);
            mdl_ptr = (g + 1) % NI;
        end
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < NI; i++) if (src_q[i].size() > 0) return 1;
        return 0;
    endfunction

    task automatic wait_drain(input int max_cycles);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || src_busy()) && cyc < max_cycles) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_remaining_beats", exp_q.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin : driver
        logic [NI-1:0] fire;
        logic [24:0] ent;
        bit gap;
        S_udp_valid  = '0;
        S_udp_data   = '0;
        S_udp_last   = '0;
        S_udp_length = '0;
        M_udp_ready  = 1'b0;
        src_mid      = '0;
        forever begin
            @(negedge clk);
            fire = S_udp_valid & S_udp_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (fire[i] && src_q[i].size() > 0) begin
                    ent = src_q[i].pop_front();
                    src_mid[i] = !ent[8];
                end
                gap = src_mid[i] && ($urandom_range(0, 99) < gap_pct);
                if (src_q[i].size() > 0 && !gap) begin
                    ent = src_q[i][0];
                    S_udp_valid[i]           = 1'b1;
                    S_udp_data[i*8 +: 8]     = ent[7:0];
                    S_udp_last[i]            = ent[8];
                    S_udp_length[i*LW +: LW] = ent[24:9];
                end else begin
                    S_udp_valid[i] = 1'b0;
                end
            end
            M_udp_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [27:0] e;
        logic [NI-1:0] exp_ready;
        bit pending_err;
        bit prev_last;
        bit prev2_last;
        bit this_last;
        pending_err = 0;
        prev_last   = 0;
        prev2_last  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending_err = 0;
                prev_last   = 0;
                prev2_last  = 0;
                continue;
            end
            check("length_error", Length_error, pending_err);
            pending_err = 0;
            exp_ready = (Grant_active && M_udp_ready) ? (NI'(1) << Grant_index) : '0;
            check("s_udp_ready", S_udp_ready, exp_ready);
            if (!Grant_active) check("idle_no_valid", M_udp_valid, 0);
            if (strict) begin
                if (prev_last) check("bubble_cycle", {Grant_active, M_udp_valid}, 0);
                if (prev2_last && exp_q.size() > 0) check("regrant_after_bubble", M_udp_valid, 1);
            end
            this_last = 0;
            if (M_udp_valid && M_udp_ready) begin
                beat_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_index", Grant_index, e[27:26]);
                    check("m_udp_data", M_udp_data, e[7:0]);
                    check("m_udp_last", M_udp_last, e[8]);
                    check("m_udp_length", M_udp_length, e[24:9]);
                    pending_err = e[25];
                end
                this_last = M_udp_last;
            end
            prev2_last = prev_last;
            prev_last  = this_last;
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int base;
        int cyc;
        int n;
        int decl;
        n_checks   = 0;
        n_fail     = 0;
        beat_count = 0;
        mdl_ptr    = 0;
        ready_pct  = 100;
        gap_pct    = 0;
        strict     = 0;
        rst_n      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_grant_active", Grant_active, 0);
        check("rst_grant_index", Grant_index, 0);
        check("rst_fsm_state", Fsm_state, 0);
        check("rst_m_udp_valid", M_udp_valid, 0);
        check("rst_s_udp_ready", S_udp_ready, 0);
        check("rst_length_error", Length_error, 0);
        #2 rst_n = 1'b1;

        // fairness: every input offers three 3-byte packets
        @(negedge clk);
        strict = 1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < NI; i++) send_packet(i, 3, 3, 0);
        build_expected();
        wait_drain(500);

        // single input 2, bytes 1..5, grant visible one cycle after valid
        @(negedge clk);
        send_packet(2, 5, 5, 1);
        build_expected();
        @(negedge clk);
        check("grant_not_yet_active", Grant_active, 0);
        @(negedge clk);
        check("grant_latency_index", Grant_index, 2);
        check("grant_latency_active", Grant_active, 1);
        wait_drain(100);

        // overrun on input 1, then a clean packet
        @(negedge clk);
        send_packet(1, 4, 6, 1);
        send_packet(2, 3, 3, 1);
        build_expected();
        wait_drain(200);

        // short packet and zero-length declaration
        @(negedge clk);
        send_packet(3, 8, 2, 1);
        build_expected();
        wait_drain(100);
        @(negedge clk);
        send_packet(0, 0, 1, 1);
        send_packet(1, 2, 2, 0);
        build_expected();
        wait_drain(100);

        // random traffic with backpressure and mid-packet valid gaps
        strict    = 0;
        ready_pct = 80;
        gap_pct   = 10;
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            for (int p = 0; p < 20; p++) begin
                n    = $urandom_range(1, 300);
                decl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 300) : n;
                send_packet($urandom_range(0, NI - 1), decl, n, 0);
            end
            build_expected();
            wait_drain(12000);
        end

        // reset after 3 of 10 bytes
        ready_pct = 100;
        gap_pct   = 0;
        @(negedge clk);
        send_packet(1, 10, 10, 1);
        build_expected();
        base = beat_count;
        cyc  = 0;
        while (beat_count - base < 3 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("beats_before_reset", beat_count - base, 3);
        #3 rst_n = 1'b0;
        #1;
        check("async_m_udp_valid", M_udp_valid, 0);
        check("async_s_udp_ready", S_udp_ready, 0);
        check("async_m_udp_last", M_udp_last, 0);
        check("async_m_udp_data", M_udp_data, 0);
        check("async_m_udp_length", M_udp_length, 0);
        check("async_grant_active", Grant_active, 0);
        for (int i = 0; i < NI; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
        end
        src_mid = '0;
        exp_q.delete();
        mdl_ptr = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        check("post_reset_fsm_state", Fsm_state, 0);
        check("post_reset_grant_index", Grant_index, 0);
        @(negedge clk);
        strict = 1;
        for (int i = 0; i < NI; i++) send_packet(i, 2, 2, 0);
        build_expected();
        wait_drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
Packet-level round-robin arbiter that merges NUM_INPUTS independent UDP byte streams (length/data/valid/last/ready, as produced by the AXI-to-UDP converters) onto one UDP transmit port feeding the Ethernet framer. The grant is held for a whole packet, so packets are never interleaved. Each packet's byte count is checked against its declared length. The block reports which input owns the current packet.

Parameters:
NUM_INPUTS, 4, number of requesting UDP streams (2..16).
LENGTH_WIDTH, 16, width of every length field; matches eth_udp_length_width.
INDEX_WIDTH, $clog2(NUM_INPUTS), width of the grant index.

Ports:
Clk  in  1  system clock; all logic is rising-edge.
Rst_n  in  1  asynchronous active-low reset.
S_udp_valid  in  NUM_INPUTS  per-input byte valid.
S_udp_data  in  NUM_INPUTS*8  per-input byte; input i uses bits [i*8 +: 8].
S_udp_last  in  NUM_INPUTS  per-input last byte of the packet.
S_udp_length  in  NUM_INPUTS*LENGTH_WIDTH  per-input packet length in bytes; must be stable for the whole packet.
S_udp_ready  out  NUM_INPUTS  per-input ready; at most one bit is high.
M_udp_valid  out  1  output byte valid.
M_udp_data  out  8  output byte.
M_udp_last  out  1  output last byte.
M_udp_length  out  LENGTH_WIDTH  length of the current packet.
M_udp_ready  in  1  downstream ready.
Grant_index  out  INDEX_WIDTH  input that owns the current packet.
Grant_active  out  1  high while a packet is granted.
Length_error  out  1  one-cycle pulse on a length mismatch.

Behaviour:
- States: S_IDLE, S_ACTIVE.
- Reset (async assert, sync release): state S_IDLE, rr_pointer 0, Grant_index 0, Grant_active 0, byte_count 0, Length_error 0.
  - All outputs go low immediately on assertion: M_udp_valid, M_udp_last, S_udp_ready, M_udp_data and M_udp_length.
  - Reset mid-packet abandons the packet. No flush; the source must also be reset.
- S_IDLE:
  - S_udp_ready = 0 and M_udp_valid = 0.
  - If any S_udp_valid is high, pick the first valid input scanning rr_pointer, rr_pointer+1, ... modulo NUM_INPUTS.
  - Register the winner into Grant_index, set Grant_active, clear byte_count, go to S_ACTIVE.
  - Net cost is exactly one bubble cycle per packet (arbitration cycle).
- S_ACTIVE, with g = Grant_index:
  - M_udp_valid = S_udp_valid[g]; M_udp_data, M_udp_last and M_udp_length come from input g.
  - S_udp_ready[g] = M_udp_ready; all other ready bits are 0.
  - This path is combinational: zero-latency pass-through, no data registers.
- Handshake: a beat transfers when M_udp_valid && M_udp_ready.
  - byte_count (LENGTH_WIDTH+1 bits, saturating) increments on every transfer.
  - Valid may drop mid-packet; the grant is held regardless.
- End of packet: a transfer with M_udp_last = 1:
  - Go to S_IDLE and clear Grant_active.
  - Set rr_pointer = (g+1) mod NUM_INPUTS, wrapping at NUM_INPUTS-1 -> 0.
- Length check on the last transfer: if byte_count+1 != M_udp_length, pulse Length_error for one cycle (registered, the cycle after the last beat). Data is still forwarded unmodified.
- Overrun: if byte_count reaches M_udp_length with no last seen, Length_error pulses once at that point. The packet continues until last; no second pulse.
- A zero-length declaration with a single-byte packet gives a mismatch and the pulse.
- Inputs not granted see ready = 0 and must hold their data (AXI rule).
- No timeout: a granted source that never asserts last stalls the port indefinitely (by design).

Test Plan:
- Single input: NUM_INPUTS=4, input 2 sends 5 bytes 0x01..0x05 with length=5, M_udp_ready held high. Expected: Grant_index=2 one cycle after valid; 5 consecutive output beats; last on 0x05; Length_error stays 0; S_udp_ready[0,1,3] stay 0.
- Fairness: all 4 inputs continuously offer 3-byte packets. Expected grant order 0,1,2,3,0,1,... with exactly one idle cycle between packets; no byte interleaving.
- Backpressure: M_udp_ready randomly 80% high (as in the UDP benches) over 200 random packets of 1..300 bytes. Expected: output bytes per input match sent bytes in order; M_udp_length equals the sent length for every packet.
- Length mismatch: input 1 declares length=4 but sends 6 bytes. Expected: Length_error pulses once after the 4th byte; all 6 bytes are forwarded; the next packet arbitrates normally with no further pulse.
- Short packet: input 3 declares length=8 and sends 2 bytes with last. Expected: Length_error pulses the cycle after the 2nd beat.
- Reset mid-packet: assert Rst_n=0 after 3 of 10 bytes. Expected: M_udp_valid and all S_udp_ready go 0 asynchronously; after release, state is S_IDLE and rr_pointer=0, so input 0 wins if all inputs are valid.
